// File: rtl/hilo_ctrl_pkg.sv
// Shared HI/LO controller definitions: op codes, FSM states and op-class helpers.
package hilo_ctrl_pkg;

    localparam logic [3:0] HILO_NOP   = 4'd0;
    localparam logic [3:0] HILO_MULT  = 4'd1;
    localparam logic [3:0] HILO_MULTU = 4'd2;
    localparam logic [3:0] HILO_MADD  = 4'd3;
    localparam logic [3:0] HILO_MADDU = 4'd4;
    localparam logic [3:0] HILO_MSUB  = 4'd5;
    localparam logic [3:0] HILO_MSUBU = 4'd6;
    localparam logic [3:0] HILO_MTHI  = 4'd7;
    localparam logic [3:0] HILO_MTLO  = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_WAIT = 3'd1,
        ST_ACC      = 3'd2,
        ST_DONE     = 3'd3,
        ST_DRAIN    = 3'd4
    } state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return op inside {HILO_MULT, HILO_MULTU, HILO_MADD, HILO_MADDU, HILO_MSUB, HILO_MSUBU};
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return op inside {HILO_MULT, HILO_MADD, HILO_MSUB};
    endfunction

    function automatic logic is_acc_op(input logic [3:0] op);
        return op inside {HILO_MADD, HILO_MADDU, HILO_MSUB, HILO_MSUBU};
    endfunction

    function automatic logic is_sub_op(input logic [3:0] op);
        return op inside {HILO_MSUB, HILO_MSUBU};
    endfunction

    // Any op that reads or writes HI/LO; NOP and the unused codes are excluded.
    function automatic logic is_hilo_op(input logic [3:0] op);
        return is_mul_op(op) || op == HILO_MTHI || op == HILO_MTLO;
    endfunction

endpackage

// File: rtl/hilo_acc.sv
// Combinational {hi,lo} accumulate: adds or subtracts the product, modulo 2^W.
module hilo_acc #(
    parameter int W = 64
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] prod,
    input  logic         sub,
    output logic [W-1:0] res
);

    assign res = sub ? (acc - prod) : (acc + prod);

endmodule

// File: rtl/hilo_ctrl.sv
// EX-stage HI/LO controller: drives the multi-cycle multiplier, accumulates and commits HI/LO.
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    input  logic [3:0]          op_i,
    input  logic [DATA_W-1:0]   rs_i,
    input  logic [DATA_W-1:0]   rt_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                mul_start_o,
    output logic                mul_signed_o,
    output logic [DATA_W-1:0]   mul_a_o,
    output logic [DATA_W-1:0]   mul_b_o,
    input  logic                mul_done_i,
    input  logic [2*DATA_W-1:0] mul_result_i,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                busy_o
);

    state_t                state_reg;
    logic [3:0]            op_reg;
    logic [DATA_W-1:0]     hi_reg;
    logic [DATA_W-1:0]     lo_reg;
    logic [2*DATA_W-1:0]   res_reg;
    logic [2*DATA_W-1:0]   prod_reg;
    logic [2*DATA_W-1:0]   acc_next;
    logic                  stall_reg;
    logic                  start_reg;
    logic                  signed_reg;
    logic [DATA_W-1:0]     a_reg;
    logic [DATA_W-1:0]     b_reg;

    hilo_acc #(
        .W (2*DATA_W)
    ) u_acc (
        .acc  ({hi_reg, lo_reg}),
        .prod (prod_reg),
        .sub  (is_sub_op(op_reg)),
        .res  (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            op_reg     <= HILO_NOP;
            hi_reg     <= '0;
            lo_reg     <= '0;
            res_reg    <= '0;
            prod_reg   <= '0;
            stall_reg  <= 1'b0;
            start_reg  <= 1'b0;
            signed_reg <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
        end else begin
            start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (op_valid && !flush_i) begin
                        if (is_mul_op(op_i)) begin
                            op_reg     <= op_i;
                            a_reg      <= rs_i;
                            b_reg      <= rt_i;
                            signed_reg <= is_signed_op(op_i);
                            start_reg  <= 1'b1;
                            stall_reg  <= 1'b1;
                            state_reg  <= ST_MUL_WAIT;
                        end else if (op_i == HILO_MTHI) begin
                            hi_reg <= rs_i;
                        end else if (op_i == HILO_MTLO) begin
                            lo_reg <= rs_i;
                        end
                    end
                end
                ST_MUL_WAIT: begin
                    if (flush_i) begin
                        // A product arriving with the flush needs no draining.
                        stall_reg <= 1'b0;
                        state_reg <= mul_done_i ? ST_IDLE : ST_DRAIN;
                    end else if (mul_done_i) begin
                        if (is_acc_op(op_reg)) begin
                            prod_reg  <= mul_result_i;
                            state_reg <= ST_ACC;
                        end else begin
                            res_reg   <= mul_result_i;
                            stall_reg <= 1'b0;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_ACC: begin
                    stall_reg <= 1'b0;
                    if (flush_i) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        res_reg   <= acc_next;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!flush_i) begin
                        {hi_reg, lo_reg} <= res_reg;
                    end
                    state_reg <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (mul_done_i) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    stall_reg <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // While draining, only a new HI/LO instruction has to wait for the orphaned product.
    assign stall_o      = stall_reg || (state_reg == ST_DRAIN && op_valid && is_hilo_op(op_i));
    assign mul_start_o  = start_reg;
    assign mul_signed_o = signed_reg;
    assign mul_a_o      = a_reg;
    assign mul_b_o      = b_reg;
    assign hi_o         = hi_reg;
    assign lo_o         = lo_reg;
    assign busy_o       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with a fixed-latency multiplier stub and a HI/LO scoreboard.
module tb_hilo_ctrl;

    localparam int W   = 32;
    localparam int LAT = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           op_valid = 1'b0;
    logic [3:0]     op_i = 4'd0;
    logic [W-1:0]   rs_i = '0;
    logic [W-1:0]   rt_i = '0;
    logic           flush_i = 1'b0;
    logic           mul_done_i = 1'b0;
    logic [2*W-1:0] mul_result_i = '0;
    logic           stall_o;
    logic           mul_start_o;
    logic           mul_signed_o;
    logic [W-1:0]   mul_a_o;
    logic [W-1:0]   mul_b_o;
    logic [W-1:0]   hi_o;
    logic [W-1:0]   lo_o;
    logic           busy_o;

    int checks = 0;
    int passes = 0;
    logic [63:0] exp_q[$];

    hilo_ctrl #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_i         (op_i),
        .rs_i         (rs_i),
        .rt_i         (rt_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .mul_start_o  (mul_start_o),
        .mul_signed_o (mul_signed_o),
        .mul_a_o      (mul_a_o),
        .mul_b_o      (mul_b_o),
        .mul_done_i   (mul_done_i),
        .mul_result_i (mul_result_i),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Multiplier stub: done pulses LAT cycles after the start cycle; cannot be cancelled.
    int          mul_cnt = 0;
    logic [63:0] mul_pend = '0;
    always @(negedge clk) begin
        mul_done_i = 1'b0;
        if (mul_cnt > 0) begin
            mul_cnt = mul_cnt - 1;
            if (mul_cnt == 0) begin
                mul_done_i   = 1'b1;
                mul_result_i = mul_pend;
            end
        end
        if (mul_start_o) begin
            mul_cnt = LAT;
            if (mul_signed_o)
                mul_pend = $signed({{32{mul_a_o[31]}}, mul_a_o}) * $signed({{32{mul_b_o[31]}}, mul_b_o});
            else
                mul_pend = {32'd0, mul_a_o} * {32'd0, mul_b_o};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    task automatic mul_txn(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input logic exp_sgn,
                           input int exp_stall);
        int stalls = 0;
        int starts = 0;
        int cyc = 0;
        logic [63:0] want;
        @(negedge clk);
        op_valid = 1'b1; op_i = op; rs_i = a; rt_i = b;
        exp_q.push_back(exp);
        @(negedge clk);
        op_valid = 1'b0; op_i = 4'd0;
        check({tag, "_start"}, {63'd0, mul_start_o}, 64'd1);
        check({tag, "_signed"}, {63'd0, mul_signed_o}, {63'd0, exp_sgn});
        check({tag, "_ab"}, {mul_a_o, mul_b_o}, {a, b});
        while (busy_o && cyc < 100) begin
            if (stall_o) stalls++;
            if (mul_start_o) starts++;
            cyc++;
            @(negedge clk);
        end
        check({tag, "_timeout"}, {63'd0, cyc < 100}, 64'd1);
        want = exp_q.pop_front();
        check({tag, "_hilo"}, {hi_o, lo_o}, want);
        check({tag, "_stalls"}, 64'(stalls), 64'(exp_stall));
        check({tag, "_starts"}, 64'(starts), 64'd1);
        $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h stalls=%0d", tag, op, a, b, hi_o, lo_o, stalls);
    endtask

    task automatic mt_txn(input string tag, input logic [3:0] op, input logic [31:0] v,
                          input logic [63:0] exp);
        @(negedge clk);
        op_valid = 1'b1; op_i = op; rs_i = v;
        exp_q.push_back(exp);
        @(negedge clk);
        op_valid = 1'b0; op_i = 4'd0;
        check({tag, "_nostall"}, {63'd0, stall_o}, 64'd0);
        check({tag, "_hilo"}, {hi_o, lo_o}, exp_q.pop_front());
        $display("txn %s op=%0d v=%h -> hi=%h lo=%h", tag, op, v, hi_o, lo_o);
    endtask

    initial begin
        int cyc;
        logic [63:0] held;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        check("rst_ab", {mul_a_o, mul_b_o}, 64'd0);
        check("rst_flags", {60'd0, stall_o, busy_o, mul_start_o, mul_signed_o}, 64'd0);
        $display("txn reset -> hi=%h lo=%h busy=%b", hi_o, lo_o, busy_o);
        rst = 1'b0;

        mul_txn("mult",  4'd1, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 1'b1, LAT + 1);
        mul_txn("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA, 1'b0, LAT + 1);
        mt_txn("mthi1", 4'd7, 32'h1,        64'h00000001_FFFFFFFA);
        mt_txn("mtlo1", 4'd8, 32'hFFFFFFFF, 64'h00000001_FFFFFFFF);
        mul_txn("maddu", 4'd4, 32'd1, 32'd1, 64'h00000002_00000000, 1'b0, LAT + 2);
        mt_txn("mthi0", 4'd7, 32'h0, 64'h00000000_00000000);
        mt_txn("mtlo0", 4'd8, 32'h0, 64'h00000000_00000000);
        mul_txn("msub",  4'd5, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 1'b1, LAT + 2);
        mul_txn("madd",  4'd3, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b1, LAT + 2);

        // Unused op code 9 and a flushed MTHI must leave everything alone.
        @(negedge clk);
        op_valid = 1'b1; op_i = 4'd9; rs_i = 32'h1234;
        @(negedge clk);
        check("nop9_idle", {62'd0, busy_o, mul_start_o}, 64'd0);
        op_i = 4'd7; flush_i = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; op_i = 4'd0; flush_i = 1'b0;
        check("flushed_mthi", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
        $display("txn nop9+flushed_mthi -> hi=%h lo=%h", hi_o, lo_o);

        // MULT flushed in its second MUL_WAIT cycle, then MTLO waits out the drain.
        held = {hi_o, lo_o};
        @(negedge clk);
        op_valid = 1'b1; op_i = 4'd1; rs_i = 32'd2; rt_i = 32'd3;
        @(negedge clk);
        op_valid = 1'b0; op_i = 4'd0;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("drain_busy", {62'd0, busy_o, stall_o}, 64'd2);
        check("drain_hilo", {hi_o, lo_o}, held);
        op_valid = 1'b1; op_i = 4'd8; rs_i = 32'h55;
        exp_q.push_back({held[63:32], 32'h55});
        #1;
        check("drain_mtlo_stall", {63'd0, stall_o}, 64'd1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (stall_o && cyc < 20);
        check("drain_len", 64'(cyc), 64'd3);
        check("drain_hilo_held", {hi_o, lo_o}, held);
        @(negedge clk);
        op_valid = 1'b0; op_i = 4'd0;
        check("drain_mtlo", {hi_o, lo_o}, exp_q.pop_front());
        $display("txn flush+drain+mtlo -> hi=%h lo=%h drain_cycles=%0d", hi_o, lo_o, cyc);

        // Reset while the multiplier is busy; its late product must be ignored.
        @(negedge clk);
        op_valid = 1'b1; op_i = 4'd1; rs_i = 32'd5; rt_i = 32'd7;
        @(negedge clk);
        op_valid = 1'b0; op_i = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(64'd0);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_hilo", {hi_o, lo_o}, 64'd0);
        check("midrst_ab", {mul_a_o, mul_b_o}, 64'd0);
        check("midrst_flags", {60'd0, stall_o, busy_o, mul_start_o, mul_signed_o}, 64'd0);
        repeat (6) @(negedge clk);
        check("stray_done_hilo", {hi_o, lo_o}, exp_q.pop_front());
        check("stray_done_idle", {62'd0, busy_o, stall_o}, 64'd0);
        $display("txn midop_reset+stray_done -> hi=%h lo=%h busy=%b", hi_o, lo_o, busy_o);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
